// File: rtl/ref_shallow_fifo_ctrl.sv
// FIFO controller around a shallow RAM with a registered read port: entries are
// written straight into the RAM and prefetched into a two-entry output buffer.
module ref_shallow_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int NUM_WORDS = 1 << ADDR_WIDTH;
    localparam int CW        = ADDR_WIDTH + 1;
    localparam int LW        = ADDR_WIDTH + 2;

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; valid never waits on ready, and in_ready looks only at registered state.
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         ram_cnt, ram_cnt_n;
    logic                  in_flight;
    logic                  head_valid, head_valid_n;
    logic                  skid_valid, skid_valid_n;
    logic [DATA_WIDTH-1:0] head_data, head_data_n;
    logic [DATA_WIDTH-1:0] skid_data, skid_data_n;
    logic [LW-1:0]         level_n;
    logic [1:0]            pending;
    logic                  wr, pop, fetch;

    assign in_ready    = !rst && (ram_cnt < CW'(NUM_WORDS));
    assign wr          = in_valid && in_ready;
    assign pop         = head_valid && out_ready;
    assign ram_wr_en   = wr;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr;
    assign out_valid   = head_valid;
    assign out_data    = head_data;

    // Buffer slots already claimed after this cycle's pop; never exceeds 2,
    // and pop implies head_valid, so the subtraction cannot underflow.
    assign pending = 2'(head_valid) + 2'(skid_valid) + 2'(in_flight) - 2'(pop);
    assign fetch   = (ram_cnt != '0) && (pending < 2'd2);

    always_comb begin
        ram_cnt_n    = ram_cnt;
        head_valid_n = head_valid;
        head_data_n  = head_data;
        skid_valid_n = skid_valid;
        skid_data_n  = skid_data;

        case ({wr, fetch})
            2'b10:   ram_cnt_n = ram_cnt + CW'(1);
            2'b01:   ram_cnt_n = ram_cnt - CW'(1);
            default: ram_cnt_n = ram_cnt;
        endcase

        if (pop) begin
            if (skid_valid) begin
                head_data_n = skid_data;
                if (in_flight) begin
                    skid_data_n = ram_rd_data;
                end else begin
                    skid_valid_n = 1'b0;
                end
            end else if (in_flight) begin
                head_data_n = ram_rd_data;
            end else begin
                head_valid_n = 1'b0;
            end
        end else if (in_flight) begin
            if (!head_valid) begin
                head_valid_n = 1'b1;
                head_data_n  = ram_rd_data;
            end else begin
                skid_valid_n = 1'b1;
                skid_data_n  = ram_rd_data;
            end
        end

        level_n = LW'(ram_cnt_n) + LW'(fetch) + LW'(head_valid_n) + LW'(skid_valid_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            in_flight  <= 1'b0;
            head_valid <= 1'b0;
            head_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            level      <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            ram_cnt    <= ram_cnt_n;
            in_flight  <= fetch;
            head_valid <= head_valid_n;
            head_data  <= head_data_n;
            skid_valid <= skid_valid_n;
            skid_data  <= skid_data_n;
            level      <= level_n;
        end
    end

endmodule
